// File: rtl/atom_bus_router_pkg.sv
// Shared definitions for the atom bus router: FSM encoding,
// default error data and the default SoC memory map.
package atom_bus_router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

    localparam logic [127:0] DEF_BASE_ADDRS = {
        32'h3000_0000,
        32'h2000_0000,
        32'h1000_0000,
        32'h0000_0000
    };

    localparam logic [127:0] DEF_ADDR_MASKS = {
        32'hF000_0000,
        32'hF000_0000,
        32'hF000_0000,
        32'hF000_0000
    };

    // Width needed to hold values 0..n-1, never less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/atom_addr_decoder.sv
// Combinational priority address decoder: the lowest-indexed
// matching region wins when regions overlap.
module atom_addr_decoder
    import atom_bus_router_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned ADDR_W = 32,
    parameter logic [NUM_PORTS*ADDR_W-1:0] BASE_ADDRS = DEF_BASE_ADDRS,
    parameter logic [NUM_PORTS*ADDR_W-1:0] ADDR_MASKS = DEF_ADDR_MASKS,
    parameter int unsigned IDX_W = clog2_min1(NUM_PORTS)
) (
    input  logic [ADDR_W-1:0]    addr_i,
    output logic                 hit_o,
    output logic [NUM_PORTS-1:0] onehot_o,
    output logic [IDX_W-1:0]     idx_o
);

    logic [NUM_PORTS-1:0] match;

    // Raw region match for every port.
    always_comb begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            match[k] = (addr_i & ADDR_MASKS[k*ADDR_W +: ADDR_W])
                       == BASE_ADDRS[k*ADDR_W +: ADDR_W];
        end
    end

    // Scan from the top so the lowest matching port is kept last.
    always_comb begin
        hit_o    = 1'b0;
        onehot_o = '0;
        idx_o    = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (match[k]) begin
                hit_o    = 1'b1;
                onehot_o = '0;
                onehot_o[k] = 1'b1;
                idx_o    = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/atom_bus_router.sv
// Single-master to NUM_PORTS-slave router with address decode,
// decode-error and per-transaction timeout responses.
module atom_bus_router
    import atom_bus_router_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter logic [NUM_PORTS*ADDR_W-1:0] BASE_ADDRS = DEF_BASE_ADDRS,
    parameter logic [NUM_PORTS*ADDR_W-1:0] ADDR_MASKS = DEF_ADDR_MASKS,
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = DEF_ERR_DATA
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [ADDR_W-1:0]           m_addr_i,
    input  logic [DATA_W-1:0]           m_data_i,
    input  logic [DATA_W/8-1:0]         m_sel_i,
    input  logic                        m_we_i,
    input  logic                        m_valid_i,
    output logic [DATA_W-1:0]           m_data_o,
    output logic                        m_ack_o,
    output logic [ADDR_W-1:0]           s_addr_o,
    output logic [DATA_W-1:0]           s_data_o,
    output logic [DATA_W/8-1:0]         s_sel_o,
    output logic                        s_we_o,
    output logic [NUM_PORTS-1:0]        s_valid_o,
    input  logic [NUM_PORTS*DATA_W-1:0] s_data_i,
    input  logic [NUM_PORTS-1:0]        s_ack_i,
    output logic                        err_o,
    output logic [ADDR_W-1:0]           err_addr_o
);

    localparam int unsigned SEL_W = DATA_W / 8;
    localparam int unsigned IDX_W = clog2_min1(NUM_PORTS);
    localparam int unsigned CNT_W = clog2_min1(TIMEOUT_CYC + 1);
    localparam bit          TO_EN = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [SEL_W-1:0]     be_q, be_d;
    logic                 we_q, we_d;
    logic [NUM_PORTS-1:0] port_oh_q, port_oh_d;
    logic [IDX_W-1:0]     port_idx_q, port_idx_d;
    logic                 miss_q, miss_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic [ADDR_W-1:0]    err_addr_q, err_addr_d;

    logic                 dec_hit;
    logic [NUM_PORTS-1:0] dec_oh;
    logic [IDX_W-1:0]     dec_idx;
    logic                 slv_ack;
    logic [DATA_W-1:0]    slv_data;

    atom_addr_decoder #(
        .NUM_PORTS  (NUM_PORTS),
        .ADDR_W     (ADDR_W),
        .BASE_ADDRS (BASE_ADDRS),
        .ADDR_MASKS (ADDR_MASKS),
        .IDX_W      (IDX_W)
    ) u_dec (
        .addr_i   (m_addr_i),
        .hit_o    (dec_hit),
        .onehot_o (dec_oh),
        .idx_o    (dec_idx)
    );

    assign slv_ack = |(s_ack_i & port_oh_q);

    // Response mux: read data of the latched target port.
    always_comb begin
        slv_data = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (port_idx_q == IDX_W'(k)) begin
                slv_data = s_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state logic. A decode miss spends its first cycle in
    // BUSY with no port selected, so it shares the ERR ack cycle
    // with timeouts and still acks two cycles after the request.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        we_d       = we_q;
        port_oh_d  = port_oh_q;
        port_idx_d = port_idx_q;
        miss_d     = miss_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        err_addr_d = err_addr_q;

        if (state_q == ST_BUSY && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (m_valid_i) begin
                    addr_d     = m_addr_i;
                    wdata_d    = m_data_i;
                    be_d       = m_sel_i;
                    we_d       = m_we_i;
                    port_oh_d  = dec_oh;
                    port_idx_d = dec_idx;
                    miss_d     = !dec_hit;
                    cnt_d      = '0;
                    state_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (miss_q) begin
                    rdata_d    = ERR_DATA;
                    err_addr_d = addr_q;
                    state_d    = ST_ERR;
                end else if (slv_ack) begin
                    rdata_d = slv_data;
                    state_d = ST_RESP;
                end else if (TO_EN && cnt_q == TO_LAST) begin
                    rdata_d    = ERR_DATA;
                    err_addr_d = addr_q;
                    state_d    = ST_ERR;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any transaction.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            we_q       <= 1'b0;
            port_oh_q  <= '0;
            port_idx_q <= '0;
            miss_q     <= 1'b0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            we_q       <= we_d;
            port_oh_q  <= port_oh_d;
            port_idx_q <= port_idx_d;
            miss_q     <= miss_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign m_ack_o    = (state_q == ST_RESP) || (state_q == ST_ERR);
    assign err_o      = (state_q == ST_ERR);
    assign s_valid_o  = (state_q == ST_BUSY && !miss_q) ? port_oh_q : '0;
    assign m_data_o   = rdata_q;
    assign err_addr_o = err_addr_q;
    assign s_addr_o   = addr_q;
    assign s_data_o   = wdata_q;
    assign s_sel_o    = be_q;
    assign s_we_o     = we_q;

endmodule

// File: tb/tb_atom_bus_router.sv
// Randomised self-checking bench for atom_bus_router against a
// transaction-level model of decode, latency and error rules.
module tb_atom_bus_router;

    localparam int NP = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
    localparam logic [NP*AW-1:0] BASES = {
        32'h0000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000
    };
    localparam logic [NP*AW-1:0] MASKS = {
        32'hC000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000
    };

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic [AW-1:0]    m_addr_i;
    logic [DW-1:0]    m_data_i;
    logic [DW/8-1:0]  m_sel_i;
    logic             m_we_i;
    logic             m_valid_i;
    logic [DW-1:0]    m_data_o;
    logic             m_ack_o;
    logic [AW-1:0]    s_addr_o;
    logic [DW-1:0]    s_data_o;
    logic [DW/8-1:0]  s_sel_o;
    logic             s_we_o;
    logic [NP-1:0]    s_valid_o;
    logic [NP*DW-1:0] s_data_i;
    logic [NP-1:0]    s_ack_i;
    logic             err_o;
    logic [AW-1:0]    err_addr_o;

    atom_bus_router #(
        .NUM_PORTS   (NP),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .BASE_ADDRS  (BASES),
        .ADDR_MASKS  (MASKS),
        .TIMEOUT_CYC (TO),
        .ERR_DATA    (ERRD)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .m_addr_i   (m_addr_i),
        .m_data_i   (m_data_i),
        .m_sel_i    (m_sel_i),
        .m_we_i     (m_we_i),
        .m_valid_i  (m_valid_i),
        .m_data_o   (m_data_o),
        .m_ack_o    (m_ack_o),
        .s_addr_o   (s_addr_o),
        .s_data_o   (s_data_o),
        .s_sel_o    (s_sel_o),
        .s_we_o     (s_we_o),
        .s_valid_o  (s_valid_o),
        .s_data_i   (s_data_i),
        .s_ack_i    (s_ack_i),
        .err_o      (err_o),
        .err_addr_o (err_addr_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] last_data;
    logic [31:0] last_err_addr;

    logic [31:0] mbase [NP] = '{32'h0000_0000, 32'h1000_0000,
                                32'h2000_0000, 32'h0000_0000};
    logic [31:0] mmask [NP] = '{32'hF000_0000, 32'hF000_0000,
                                32'hF000_0000, 32'hC000_0000};

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ref_port(input logic [31:0] a);
        for (int k = 0; k < NP; k++) begin
            if ((a & mmask[k]) == mbase[k]) return k;
        end
        return -1;
    endfunction

    task automatic noise();
        s_ack_i  = 4'($urandom);
        s_data_i = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // One transaction; slave acks dly cycles after s_valid first
    // shows (dly >= TO never acks in time).
    task automatic do_txn(input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input logic we,
                          input int dly, input logic [31:0] rd,
                          input bit drop);
        int port;
        int lat;
        bit e;
        logic [31:0] xd;
        logic [3:0] xv;
        port = ref_port(a);
        if (port < 0) begin
            e = 1'b1;
            lat = 2;
        end else if (dly < TO) begin
            e = 1'b0;
            lat = dly + 2;
        end else begin
            e = 1'b1;
            lat = TO + 1;
        end
        xd = e ? ERRD : rd;
        xv = (port < 0) ? 4'b0000 : 4'(1 << port);
        @(negedge clk_i);
        check("idle_ack", 64'(m_ack_o), 64'd0);
        check("idle_valid", 64'(s_valid_o), 64'd0);
        check("hold_data", 64'(m_data_o), 64'(last_data));
        check("hold_eaddr", 64'(err_addr_o), 64'(last_err_addr));
        m_addr_i  = a;
        m_data_i  = wd;
        m_sel_i   = be;
        m_we_i    = we;
        m_valid_i = 1'b1;
        noise();
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk_i);
            if (drop) m_valid_i = 1'b0;
            if (c < lat) begin
                check("busy_ack", 64'(m_ack_o), 64'd0);
                check("s_valid", 64'(s_valid_o), 64'(xv));
                if (c == 1 && port >= 0) begin
                    check("s_addr", 64'(s_addr_o), 64'(a));
                    check("s_data", 64'(s_data_o), 64'(wd));
                    check("s_sel", 64'(s_sel_o), 64'(be));
                    check("s_we", 64'(s_we_o), 64'(we));
                end
                noise();
                if (port >= 0) begin
                    s_ack_i[port] = (c - 1 == dly);
                    if (c - 1 == dly) s_data_i[port*32 +: 32] = rd;
                end
            end else begin
                if (e) last_err_addr = a;
                last_data = xd;
                check("ack", 64'(m_ack_o), 64'd1);
                check("err", 64'(err_o), 64'(e));
                check("rdata", 64'(m_data_o), 64'(xd));
                check("valid_off", 64'(s_valid_o), 64'd0);
                check("err_addr", 64'(err_addr_o), 64'(last_err_addr));
                m_valid_i = 1'b0;
                noise();
                if (e) s_ack_i = '1;
            end
        end
    endtask

    initial begin
        logic [31:0] a;
        int r;
        int dly;
        m_addr_i  = '0;
        m_data_i  = '0;
        m_sel_i   = '0;
        m_we_i    = 1'b0;
        m_valid_i = 1'b0;
        s_data_i  = '0;
        s_ack_i   = '0;
        last_data = '0;
        last_err_addr = '0;
        #2 rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_ack", 64'(m_ack_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_valid", 64'(s_valid_o), 64'd0);
        check("rst_mdata", 64'(m_data_o), 64'd0);
        check("rst_eaddr", 64'(err_addr_o), 64'd0);
        check("rst_saddr", 64'(s_addr_o), 64'd0);
        rst_i = 1'b1;

        do_txn(32'h1000_0004, 32'h0, 4'hF, 1'b0, 0, 32'hCAFE_0001, 1'b0);
        do_txn(32'hF000_0000, 32'h0, 4'hF, 1'b0, 0, 32'h1234_5678, 1'b0);
        do_txn(32'h1000_0100, 32'h0, 4'hF, 1'b0, 20, 32'h7777_7777, 1'b0);
        do_txn(32'h0000_0040, 32'h1111_2222, 4'b0011, 1'b1, 0,
               32'h5555_0000, 1'b0);
        do_txn(32'h2000_0080, 32'h3333_4444, 4'b0011, 1'b1, 1,
               32'h6666_0000, 1'b1);
        do_txn(32'h0ABC_0000, 32'h0, 4'hF, 1'b0, 2, 32'hABCD_0000, 1'b0);
        do_txn(32'h3000_0010, 32'h0, 4'hF, 1'b0, 7, 32'h3333_0003, 1'b0);

        @(negedge clk_i);
        m_addr_i  = 32'h2000_0010;
        m_valid_i = 1'b1;
        s_ack_i   = '0;
        repeat (3) @(negedge clk_i);
        check("pre_rst_valid", 64'(s_valid_o), 64'h4);
        #1 rst_i = 1'b0;
        #1;
        check("arst_valid", 64'(s_valid_o), 64'd0);
        check("arst_ack", 64'(m_ack_o), 64'd0);
        check("arst_err", 64'(err_o), 64'd0);
        check("arst_mdata", 64'(m_data_o), 64'd0);
        check("arst_eaddr", 64'(err_addr_o), 64'd0);
        check("arst_saddr", 64'(s_addr_o), 64'd0);
        check("arst_sdata", 64'(s_data_o), 64'd0);
        check("arst_ssel", 64'(s_sel_o), 64'd0);
        check("arst_swe", 64'(s_we_o), 64'd0);
        m_valid_i = 1'b0;
        s_ack_i   = 4'b0100;
        repeat (4) begin
            @(negedge clk_i);
            check("rst_no_ack", 64'(m_ack_o), 64'd0);
        end
        rst_i = 1'b1;
        s_ack_i = '0;
        last_data = '0;
        last_err_addr = '0;
        do_txn(32'h2000_0020, 32'h0, 4'hF, 1'b0, 0, 32'h2222_0002, 1'b0);

        for (int i = 0; i < 300; i++) begin
            a = {4'($urandom_range(0, 15)), 28'($urandom)};
            r = $urandom_range(0, 9);
            if (r < 6) dly = r % 3;
            else if (r < 8) dly = $urandom_range(3, 7);
            else dly = $urandom_range(8, 12);
            do_txn(a, $urandom, 4'($urandom), 1'($urandom), dly,
                   $urandom, 1'($urandom));
        end

        @(negedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
